// File: rtl/sensor_pkg.sv
// sensor_pkg: shared FSM encoding and clock-count derivation for the ultrasonic sensor blocks
package sensor_pkg;

    typedef enum logic [2:0] {
        ESPERA,
        DISPARO,
        AGUARDA_ECO,
        MEDE,
        ECO_PRESO
    } estado_t;

    // Round-trip echo time per centimetre of distance
    localparam int US_POR_CM = 58;

    function automatic int clks_us(input int freq_hz, input int us);
        return freq_hz / 1_000_000 * us;
    endfunction

    function automatic int clks_ms(input int freq_hz, input int ms);
        return freq_hz / 1000 * ms;
    endfunction

    // Counter width able to hold values 0..n-1, never narrower than one bit
    function automatic int bits(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sincronizador.sv
// sincronizador: two-flop synchronizer bringing an asynchronous level into the clk domain
module sincronizador (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
    end

endmodule

// File: rtl/sensor_ultrassonico.sv
// sensor_ultrassonico: periodic trigger generation and echo-width to centimetre measurement
module sensor_ultrassonico
    import sensor_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TRIG_US     = 10,
    parameter int PERIODO_MS  = 60,
    parameter int TIMEOUT_MS  = 38
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       echo,
    output logic       trigger,
    output logic [7:0] distancia_cm,
    output logic       valido,
    output logic       erro
);

    localparam int CLKS_TRIG    = clks_us(CLK_FREQ_HZ, TRIG_US);
    localparam int CLKS_CM      = clks_us(CLK_FREQ_HZ, US_POR_CM);
    localparam int CLKS_PERIODO = clks_ms(CLK_FREQ_HZ, PERIODO_MS);
    localparam int CLKS_TIMEOUT = clks_ms(CLK_FREQ_HZ, TIMEOUT_MS);
    localparam int PW = bits(CLKS_PERIODO);
    localparam int CW = bits(CLKS_TIMEOUT > CLKS_TRIG ? CLKS_TIMEOUT : CLKS_TRIG);
    localparam int SW = bits(CLKS_CM);
    localparam logic [PW-1:0] PER_FIM  = PW'(CLKS_PERIODO - 1);
    localparam logic [CW-1:0] TRIG_FIM = CW'(CLKS_TRIG - 1);
    localparam logic [CW-1:0] TO_FIM   = CW'(CLKS_TIMEOUT - 1);
    localparam logic [SW-1:0] CM_FIM   = SW'(CLKS_CM - 1);

    logic          echo_s;
    logic [PW-1:0] per_cnt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sub;
    logic [7:0]    cm;
    estado_t       estado;
    logic          per_wrap;
    logic          sub_fim;
    logic [SW-1:0] sub_prox;
    logic [7:0]    cm_prox;

    assign per_wrap = per_cnt == PER_FIM;
    assign sub_fim  = sub == CM_FIM;
    assign sub_prox = sub_fim ? '0 : sub + 1'b1;
    assign cm_prox  = (sub_fim && cm != 8'hFF) ? cm + 8'd1 : cm;

    sincronizador u_sinc (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (echo),
        .q    (echo_s)
    );

    // Free-running period counter; its wrap is the only trigger opportunity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) per_cnt <= '0;
        else        per_cnt <= per_wrap ? '0 : per_cnt + 1'b1;
    end

    // Measurement FSM: cnt times the trigger, the echo wait and the echo width;
    // sub/cm convert echo-high cycles into whole centimetres (truncating)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= ESPERA;
            cnt          <= '0;
            sub          <= '0;
            cm           <= '0;
            trigger      <= 1'b0;
            distancia_cm <= '0;
            valido       <= 1'b0;
            erro         <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (per_wrap) begin
                        estado  <= DISPARO;
                        trigger <= 1'b1;
                        cnt     <= '0;
                    end
                end
                DISPARO: begin
                    if (cnt == TRIG_FIM) begin
                        estado  <= AGUARDA_ECO;
                        trigger <= 1'b0;
                        cnt     <= '0;
                        sub     <= '0;
                        cm      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                AGUARDA_ECO: begin
                    if (echo_s) begin
                        estado <= MEDE;
                        cnt    <= CW'(1);
                        sub    <= sub_prox;
                        cm     <= cm_prox;
                    end else if (cnt == TO_FIM) begin
                        estado <= ESPERA;
                        erro   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEDE: begin
                    if (!echo_s) begin
                        estado       <= ESPERA;
                        distancia_cm <= cm;
                        valido       <= 1'b1;
                        erro         <= 1'b0;
                    end else if (cnt == TO_FIM) begin
                        estado <= ECO_PRESO;
                        erro   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        sub <= sub_prox;
                        cm  <= cm_prox;
                    end
                end
                ECO_PRESO: begin
                    if (!echo_s) estado <= ESPERA;
                end
                default: estado <= ESPERA;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_ultrassonico.sv
// tb_sensor_ultrassonico: directed and randomized echo widths against an arithmetic distance/timing model
module tb_sensor_ultrassonico;

    localparam int FREQ    = 1_000_000;
    localparam int TRIG_US = 10;
    localparam int PER_MS  = 3;
    localparam int TO_MS   = 2;
    localparam int TRIG    = FREQ / 1_000_000 * TRIG_US;
    localparam int CM      = FREQ / 1_000_000 * 58;
    localparam int P       = FREQ / 1000 * PER_MS;
    localparam int TO      = FREQ / 1000 * TO_MS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       echo = 1'b0;
    logic       trigger;
    logic [7:0] distancia_cm;
    logic       valido;
    logic       erro;

    int compared = 0;
    int mismatched = 0;
    int k = 0;
    int exp_prox = 0;
    int dist_esp = 0;
    int n_valido = 0;
    int bad = 0;
    int nv0 = 0;
    logic [7:0] dist_ant = '0;

    sensor_ultrassonico #(
        .CLK_FREQ_HZ(FREQ),
        .TRIG_US    (TRIG_US),
        .PERIODO_MS (PER_MS),
        .TIMEOUT_MS (TO_MS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .echo        (echo),
        .trigger     (trigger),
        .distancia_cm(distancia_cm),
        .valido      (valido),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    // Count valid strobes and flag any distance change that is not accompanied by one
    always @(negedge clk) begin
        if (valido === 1'b1) n_valido++;
        if (rst_n && distancia_cm !== dist_ant && valido !== 1'b1) bad++;
        dist_ant = distancia_cm;
    end

    function automatic int cm_de(input int w);
        return (w / CM > 255) ? 255 : w / CM;
    endfunction

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        compared++;
        assert (obs === esp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic passo();
        @(negedge clk);
        k++;
    endtask

    task automatic solta_reset();
        passo();
        rst_n = 1'b1;
        k = 0;
        exp_prox = P;
        dist_esp = 0;
    endtask

    task automatic subida(input bit largura);
        int n;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * P && !ok; i++) begin
            passo();
            ok = (trigger === 1'b1);
        end
        confere("trig_rise_at", k, exp_prox);
        confere("dist_hold", distancia_cm, dist_esp);
        if (largura) begin
            n = 1;
            for (int i = 0; i < 50 && trigger === 1'b1; i++) begin
                passo();
                if (trigger === 1'b1) n++;
            end
            confere("trig_width", n, TRIG);
        end
    endtask

    task automatic medir(input int w, input int atraso);
        subida(1'b1);
        repeat (atraso) passo();
        echo = 1'b1;
        nv0 = n_valido;
        repeat (w) passo();
        echo = 1'b0;
        repeat (6) passo();
        dist_esp = cm_de(w);
        confere("valido_once", n_valido - nv0, 1);
        confere("dist", distancia_cm, dist_esp);
        confere("erro_clear", erro, 0);
        exp_prox = (k / P + 1) * P;
    endtask

    task automatic sem_eco();
        subida(1'b1);
        repeat (TO - 1) passo();
        confere("erro_before_wait_to", erro, 0);
        passo();
        confere("erro_wait_to", erro, 1);
        confere("dist_after_wait_to", distancia_cm, dist_esp);
        repeat (2) passo();
        exp_prox = (k / P + 1) * P;
    endtask

    task automatic preso(input int w);
        int nt;
        nt = 0;
        subida(1'b1);
        repeat (50) passo();
        echo = 1'b1;
        nv0 = n_valido;
        repeat (TO + 1) begin
            passo();
            nt += int'(trigger);
        end
        confere("erro_before_echo_to", erro, 0);
        passo();
        confere("erro_echo_to", erro, 1);
        repeat (w - TO - 2) begin
            passo();
            nt += int'(trigger);
        end
        echo = 1'b0;
        confere("no_trig_while_stuck", nt, 0);
        repeat (6) passo();
        confere("no_valido_stuck", n_valido - nv0, 0);
        confere("dist_after_stuck", distancia_cm, dist_esp);
        exp_prox = (k / P + 1) * P;
    endtask

    initial begin
        repeat (3) passo();
        confere("rst_trigger", trigger, 0);
        confere("rst_dist", distancia_cm, 0);
        confere("rst_valido", valido, 0);
        confere("rst_erro", erro, 0);
        solta_reset();

        medir(1160, 40);
        medir(1217, 17);
        medir(1218, 123);
        sem_eco();
        medir(580, 30);
        medir(TO - 1, 5);
        preso(5000);
        medir(CM, 60);
        medir(CM - 1, 60);
        for (int i = 0; i < 6; i++)
            medir(int'($urandom_range(1, TO - 1)), int'($urandom_range(1, 200)));

        subida(1'b0);
        repeat (3) passo();
        #2 rst_n = 1'b0;
        #1;
        confere("rst_disparo_trigger", trigger, 0);
        confere("rst_disparo_valido", valido, 0);
        repeat (3) passo();
        solta_reset();

        medir(1160, 40);
        subida(1'b1);
        repeat (20) passo();
        echo = 1'b1;
        nv0 = n_valido;
        repeat (300) passo();
        #2 rst_n = 1'b0;
        #1;
        confere("rst_mede_trigger", trigger, 0);
        confere("rst_mede_dist", distancia_cm, 0);
        confere("rst_mede_valido", valido, 0);
        passo();
        echo = 1'b0;
        repeat (2) passo();
        solta_reset();
        subida(1'b1);
        confere("no_stale_valido", n_valido - nv0, 0);

        confere("dist_only_with_valido", bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
